// File: rtl/rv32m_div_ctrl_if.sv
// Bundle between the EX-stage divide controller, the pipeline and the
// unsigned multicycle divider. The slave side is the controller. The master
// side is everything around it: the pipeline that issues divide ops and the
// divider that returns quotient/remainder.
interface rv32m_div_ctrl_if;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        busy;
    logic        result_valid;
    logic [31:0] result;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic        div_calc;
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;
    logic        div_done;

    modport master (
        output start, funct3, rs1, rs2, div_quotient, div_remainder, div_done,
        input  busy, result_valid, result, div_dividend, div_divisor, div_calc
    );

    modport slave (
        input  start, funct3, rs1, rs2, div_quotient, div_remainder, div_done,
        output busy, result_valid, result, div_dividend, div_divisor, div_calc
    );
endinterface

// File: rtl/rv32m_div_ctrl.sv
// RV32M DIV/DIVU/REM/REMU control and sign stage around an unsigned
// multicycle divider. It converts signed operands to magnitudes, resolves
// divide-by-zero, signed overflow and (optionally) |dividend| < |divisor>
// without the divider, launches the divider otherwise, and applies result
// signs on completion.
//
// Optional build macro DIV_RESULT_REUSE_EN: remembers the operands and final
// quotient/remainder of the last divider-path op, so that a following op with
// the same rs1, rs2 and signedness (typically DIV then REM) completes straight
// from that store without launching the divider.
module rv32m_div_ctrl #(
    parameter bit BYPASS_SMALL = 1'b1
) (
    input logic            clk,
    input logic            rst,
    rv32m_div_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        DONE
    } state_t;

    state_t      state;

    logic        is_rem;
    logic        neg_q;
    logic        neg_r;
    logic [31:0] mag_dividend;
    logic [31:0] mag_divisor;
    logic        div_calc_r;
    logic        result_valid_r;
    logic [31:0] result_r;

    logic        accept;
    logic        in_signed;
    logic [31:0] in_mag1;
    logic [31:0] in_mag2;
    logic        bypass_hit;
    logic [31:0] bypass_q;
    logic [31:0] bypass_r;
    logic [31:0] fin_q;
    logic [31:0] fin_r;

`ifdef DIV_RESULT_REUSE_EN
    logic        reuse_valid;
    logic [31:0] reuse_rs1;
    logic [31:0] reuse_rs2;
    logic        reuse_signed;
    logic [31:0] reuse_q;
    logic [31:0] reuse_r;
    logic        op_signed;
    logic [31:0] op_rs1;
    logic [31:0] op_rs2;
`endif

    // funct3[2] is set for every M-extension divide encoding, so it doubles as
    // a sanity qualifier on start.
    assign accept    = bus.start & bus.funct3[2];
    assign in_signed = ~bus.funct3[0];
    assign in_mag1   = (bus.rs1[31] & in_signed) ? (32'd0 - bus.rs1) : bus.rs1;
    assign in_mag2   = (bus.rs2[31] & in_signed) ? (32'd0 - bus.rs2) : bus.rs2;

    // Sign fixup of the raw divider outputs, applied in the divider's done cycle.
    assign fin_q = neg_q ? (32'd0 - bus.div_quotient)  : bus.div_quotient;
    assign fin_r = neg_r ? (32'd0 - bus.div_remainder) : bus.div_remainder;

    // Decide whether the incoming op can finish without the divider and, if so,
    // its already sign-final quotient and remainder.
    always_comb begin
        bypass_hit = 1'b0;
        bypass_q   = 32'd0;
        bypass_r   = 32'd0;
        if (bus.rs2 == 32'd0) begin
            bypass_hit = 1'b1;
            bypass_q   = 32'hFFFF_FFFF;
            bypass_r   = bus.rs1;
        end else if (in_signed && (bus.rs1 == 32'h8000_0000) && (bus.rs2 == 32'hFFFF_FFFF)) begin
            bypass_hit = 1'b1;
            bypass_q   = 32'h8000_0000;
            bypass_r   = 32'd0;
        end else if ((BYPASS_SMALL == 1'b1) && (in_mag1 < in_mag2)) begin
            bypass_hit = 1'b1;
            bypass_q   = 32'd0;
            bypass_r   = bus.rs1;
`ifdef DIV_RESULT_REUSE_EN
        end else if (reuse_valid && (bus.rs1 == reuse_rs1) && (bus.rs2 == reuse_rs2) &&
                     (in_signed == reuse_signed)) begin
            bypass_hit = 1'b1;
            bypass_q   = reuse_q;
            bypass_r   = reuse_r;
`endif
        end
    end

    // Control FSM: operand capture, bypass or divider launch, completion capture
    // with sign fixup, and a one-cycle DONE that presents result_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            is_rem         <= 1'b0;
            neg_q          <= 1'b0;
            neg_r          <= 1'b0;
            mag_dividend   <= 32'd0;
            mag_divisor    <= 32'd0;
            div_calc_r     <= 1'b0;
            result_valid_r <= 1'b0;
            result_r       <= 32'd0;
`ifdef DIV_RESULT_REUSE_EN
            reuse_valid    <= 1'b0;
            reuse_rs1      <= 32'd0;
            reuse_rs2      <= 32'd0;
            reuse_signed   <= 1'b0;
            reuse_q        <= 32'd0;
            reuse_r        <= 32'd0;
            op_signed      <= 1'b0;
            op_rs1         <= 32'd0;
            op_rs2         <= 32'd0;
`endif
        end else begin
            div_calc_r     <= 1'b0;
            result_valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        is_rem       <= bus.funct3[1];
                        neg_q        <= in_signed & (bus.rs1[31] ^ bus.rs2[31]);
                        neg_r        <= in_signed & bus.rs1[31];
                        mag_dividend <= in_mag1;
                        mag_divisor  <= in_mag2;
`ifdef DIV_RESULT_REUSE_EN
                        op_signed    <= in_signed;
                        op_rs1       <= bus.rs1;
                        op_rs2       <= bus.rs2;
`endif
                        if (bypass_hit) begin
                            result_r       <= bus.funct3[1] ? bypass_r : bypass_q;
                            result_valid_r <= 1'b1;
                            state          <= DONE;
                        end else begin
                            div_calc_r <= 1'b1;
                            state      <= LAUNCH;
                        end
                    end
                end
                LAUNCH: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (bus.div_done) begin
                        result_r       <= is_rem ? fin_r : fin_q;
                        result_valid_r <= 1'b1;
                        state          <= DONE;
`ifdef DIV_RESULT_REUSE_EN
                        reuse_valid    <= 1'b1;
                        reuse_rs1      <= op_rs1;
                        reuse_rs2      <= op_rs2;
                        reuse_signed   <= op_signed;
                        reuse_q        <= fin_q;
                        reuse_r        <= fin_r;
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The stall covers the accepting cycle combinationally plus LAUNCH and WAIT;
    // DONE releases the pipeline so it advances with the result.
    assign bus.busy = ((state == IDLE) & accept) | (state == LAUNCH) | (state == WAIT);

    assign bus.result_valid = result_valid_r;
    assign bus.result       = result_r;
    assign bus.div_calc     = div_calc_r;
    assign bus.div_dividend = mag_dividend;
    assign bus.div_divisor  = mag_divisor;

endmodule

// File: tb/tb_rv32m_div_ctrl.sv
// Self-checking bench for rv32m_div_ctrl: a table of directed divide ops with
// hand-computed results, a behavioural divider with adjustable latency, and a
// hand-written reset-during-WAIT sequence.
module tb_rv32m_div_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rv32m_div_ctrl_if bus ();

    rv32m_div_ctrl #(.BYPASS_SMALL(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int passes = 0;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        bit          launch;
        logic [31:0] dvd;
        logic [31:0] dvs;
    } vec_t;

    vec_t vecs[$];

    // Divider model state
    int          lat = 2;
    int          cnt = 0;
    int          launches = 0;
    logic [31:0] l_dvd = 32'd0;
    logic [31:0] l_dvs = 32'd0;

    // Reuse-store model (only meaningful when the feature is built in)
    bit          rv = 1'b0;
    logic [31:0] r1 = 32'd0;
    logic [31:0] r2 = 32'd0;
    bit          rsg = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    function automatic vec_t mk(input string n, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] res, input bit launch,
                                input logic [31:0] dvd, input logic [31:0] dvs);
        vec_t v;
        v.name = n; v.f3 = f3; v.a = a; v.b = b; v.res = res;
        v.launch = launch; v.dvd = dvd; v.dvs = dvs;
        return v;
    endfunction

    // Behavioural unsigned divider driven on the falling edge: latches operands
    // on div_calc, checks they are held, and pulses div_done after lat cycles.
    always @(negedge clk) begin
        if (rst) begin
            cnt          = 0;
            bus.div_done = 1'b0;
        end else begin
            bus.div_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    checkOutput("dividend_hold", bus.div_dividend, l_dvd);
                    checkOutput("divisor_hold", bus.div_divisor, l_dvs);
                    checkOutput("busy_in_wait", {31'd0, bus.busy}, 32'd1);
                    bus.div_quotient  = (l_dvs != 32'd0) ? l_dvd / l_dvs : 32'd0;
                    bus.div_remainder = (l_dvs != 32'd0) ? l_dvd % l_dvs : 32'd0;
                    bus.div_done      = 1'b1;
                end
            end
            if (bus.div_calc) begin
                launches++;
                l_dvd = bus.div_dividend;
                l_dvs = bus.div_divisor;
                checkOutput("launch_divisor_nonzero", {31'd0, (l_dvs != 32'd0)}, 32'd1);
                cnt = lat;
            end
        end
    end

    // Issue one op, wait (bounded) for result_valid, then confirm the result holds.
    task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] res, output int cycles, output int nlaunch);
        int l0;
        @(negedge clk);
        l0         = launches;
        bus.start  = 1'b1;
        bus.funct3 = f3;
        bus.rs1    = a;
        bus.rs2    = b;
        #1;
        checkOutput("busy_start_cycle", {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        bus.start = 1'b0;
        cycles    = 1;
        while (!bus.result_valid && cycles < 60) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("result_valid_seen", {31'd0, bus.result_valid}, 32'd1);
        checkOutput("busy_in_done", {31'd0, bus.busy}, 32'd0);
        res     = bus.result;
        nlaunch = launches - l0;
        @(negedge clk);
        checkOutput("result_valid_pulse", {31'd0, bus.result_valid}, 32'd0);
        checkOutput("result_hold", bus.result, res);
    endtask

    initial begin
        logic [31:0] res;
        int          cycles;
        int          nl;
        bit          exp_launch;

        rst               = 1'b1;
        bus.start         = 1'b0;
        bus.funct3        = 3'b000;
        bus.rs1           = 32'd0;
        bus.rs2           = 32'd0;
        bus.div_quotient  = 32'd0;
        bus.div_remainder = 32'd0;
        bus.div_done      = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("rst_result_valid", {31'd0, bus.result_valid}, 32'd0);
        checkOutput("rst_result", bus.result, 32'd0);
        checkOutput("rst_div_calc", {31'd0, bus.div_calc}, 32'd0);
        checkOutput("rst_div_dividend", bus.div_dividend, 32'd0);
        checkOutput("rst_div_divisor", bus.div_divisor, 32'd0);
        rst = 1'b0;

        vecs.push_back(mk("divu_100_7",   3'b101, 32'd100,        32'd7,          32'd14,         1, 32'd100,        32'd7));
        vecs.push_back(mk("remu_100_7",   3'b111, 32'd100,        32'd7,          32'd2,          1, 32'd100,        32'd7));
        vecs.push_back(mk("div_m7_2",     3'b100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1, 32'd7,          32'd2));
        vecs.push_back(mk("rem_m7_2",     3'b110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1, 32'd7,          32'd2));
        vecs.push_back(mk("div_5_0",      3'b100, 32'd5,          32'd0,          32'hFFFF_FFFF,  0, 32'd0,          32'd0));
        vecs.push_back(mk("rem_5_0",      3'b110, 32'd5,          32'd0,          32'd5,          0, 32'd0,          32'd0));
        vecs.push_back(mk("remu_5_0",     3'b111, 32'd5,          32'd0,          32'd5,          0, 32'd0,          32'd0));
        vecs.push_back(mk("div_ovf",      3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  0, 32'd0,          32'd0));
        vecs.push_back(mk("rem_ovf",      3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          0, 32'd0,          32'd0));
        vecs.push_back(mk("divu_big_small", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,          0, 32'd0,          32'd0));
        vecs.push_back(mk("div_7_m2",     3'b100, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  1, 32'd7,          32'd2));
        vecs.push_back(mk("rem_7_m2",     3'b110, 32'd7,          32'hFFFF_FFFE,  32'd1,          1, 32'd7,          32'd2));
        vecs.push_back(mk("div_m100_m7",  3'b100, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         1, 32'd100,        32'd7));
        vecs.push_back(mk("rem_3_10",     3'b110, 32'd3,          32'd10,         32'd3,          0, 32'd0,          32'd0));
        vecs.push_back(mk("rem_m3_10",    3'b110, 32'hFFFF_FFFD,  32'd10,         32'hFFFF_FFFD,  0, 32'd0,          32'd0));
        vecs.push_back(mk("div_m3_10",    3'b100, 32'hFFFF_FFFD,  32'd10,         32'd0,          0, 32'd0,          32'd0));
        vecs.push_back(mk("divu_max_1",   3'b101, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1, 32'hFFFF_FFFF,  32'd1));
        vecs.push_back(mk("remu_max_16",  3'b111, 32'hFFFF_FFFF,  32'd16,         32'd15,         1, 32'hFFFF_FFFF,  32'd16));
        vecs.push_back(mk("div_min_2",    3'b100, 32'h8000_0000,  32'd2,          32'hC000_0000,  1, 32'h8000_0000,  32'd2));
        vecs.push_back(mk("divu_1000_33", 3'b101, 32'd1000,       32'd33,         32'd30,         1, 32'd1000,       32'd33));
        vecs.push_back(mk("remu_1000_33", 3'b111, 32'd1000,       32'd33,         32'd10,         1, 32'd1000,       32'd33));

        foreach (vecs[i]) begin
            exp_launch = vecs[i].launch;
`ifdef DIV_RESULT_REUSE_EN
            if (exp_launch) begin
                if (rv && vecs[i].a == r1 && vecs[i].b == r2 && rsg == ~vecs[i].f3[0]) begin
                    exp_launch = 1'b0;
                end else begin
                    rv = 1'b1; r1 = vecs[i].a; r2 = vecs[i].b; rsg = ~vecs[i].f3[0];
                end
            end
`endif
            applyStimulus(vecs[i].f3, vecs[i].a, vecs[i].b, res, cycles, nl);
            checkOutput({vecs[i].name, "_result"}, res, vecs[i].res);
            checkOutput({vecs[i].name, "_launches"}, nl, {31'd0, exp_launch});
            if (exp_launch) begin
                checkOutput({vecs[i].name, "_div_dividend"}, l_dvd, vecs[i].dvd);
                checkOutput({vecs[i].name, "_div_divisor"}, l_dvs, vecs[i].dvs);
            end else begin
                checkOutput({vecs[i].name, "_latency"}, cycles, 32'd1);
            end
        end

        // Reset while the divider is busy: everything returns to idle at once.
        lat = 30;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = 3'b101;
        bus.rs1    = 32'd50;
        bus.rs2    = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("busy_before_rst", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        rv  = 1'b0;
        checkOutput("wait_rst_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("wait_rst_result_valid", {31'd0, bus.result_valid}, 32'd0);
        checkOutput("wait_rst_result", bus.result, 32'd0);
        checkOutput("wait_rst_div_calc", {31'd0, bus.div_calc}, 32'd0);
        lat = 2;
        applyStimulus(3'b101, 32'd9, 32'd3, res, cycles, nl);
        checkOutput("divu_9_3_result", res, 32'd3);
        checkOutput("divu_9_3_launches", nl, 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time exceeded, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

endmodule
